lsu_align: RTL and testbench

Load/store alignment unit sitting directly upstream of `data_memory` in the MEM stage. It accepts byte-addressed RV32 load/store requests and converts them into word-indexed, word-wide accesses. Sub-word stores are performed as read-modify-write so they land on the correct byte lane. Load data is extracted by byte offset and sign/zero-extended, and misaligned or illegal requests are flagged without touching memory.

---
 rtl/lsu_align.sv | 166 ++++++++++++++++
 tb/tb_lsu_align.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/lsu_align.sv
// Load/store alignment unit in front of a word-wide data memory.
// Turns byte-addressed RV32 loads/stores into word accesses; sub-word stores use read-modify-write.
module lsu_align #(
    parameter int AW = 11,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [2:0]    req_func3,
    input  logic [31:0]   req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          resp_valid,
    output logic          resp_err,
    output logic [DW-1:0] resp_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wr,
    output logic [DW-1:0] mem_wdata,
    output logic [2:0]    mem_func3,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_WRITE, S_RMW_RD, S_RMW_WR, S_ERR, S_RESP
    } state_t;

    state_t state, state_nxt;

    logic          we_q;
    logic [2:0]    f3_q;
    logic [AW+1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] merge_q;
    logic [DW-1:0] rdata_q;
    logic          err_q;

    logic          accept;
    logic          illegal;
    logic [1:0]    off;
    logic [DW-1:0] shifted;
    logic [DW-1:0] load_ext;
    logic [DW-1:0] wdata_sh;
    logic [3:0]    byte_en;
    logic [DW-1:0] merged;

    // Upper address bits fall outside the memory and are intentionally dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^{req_addr[31:AW+2], we_q};

    assign accept = req_valid && req_ready;
    assign off    = addr_q[1:0];

    always_comb begin
        illegal = 1'b0;
        if (req_we)
            illegal = req_func3[2] || (req_func3[1:0] == 2'b11);
        else
            illegal = (req_func3 == 3'd3) || (req_func3 == 3'd6) || (req_func3 == 3'd7);
        if (req_func3[1:0] == 2'b01 && req_addr[0])
            illegal = 1'b1;
        if (req_func3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
            illegal = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (illegal)                      state_nxt = S_ERR;
                    else if (!req_we)                 state_nxt = S_LOAD;
                    else if (req_func3[1:0] == 2'b10) state_nxt = S_WRITE;
                    else                              state_nxt = S_RMW_RD;
                end
            end
            S_LOAD:   state_nxt = S_RESP;
            S_WRITE:  state_nxt = S_RESP;
            S_RMW_RD: state_nxt = S_RMW_WR;
            S_RMW_WR: state_nxt = S_RESP;
            S_ERR:    state_nxt = S_RESP;
            S_RESP:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Load extraction: shift the addressed lane down, then extend by funct3.
    assign shifted = mem_rdata >> {off, 3'b000};

    always_comb begin
        case (f3_q)
            3'd0:    load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'd1:    load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'd4:    load_ext = {24'd0, shifted[7:0]};
            3'd5:    load_ext = {16'd0, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    // Store merge: new data is pre-shifted into its lane, byte_en picks which lanes to replace.
    assign wdata_sh = wdata_q << {off, 3'b000};
    assign byte_en  = (f3_q[1:0] == 2'b00) ? (4'b0001 << off) : (4'b0011 << off);

    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign merged[8*i +: 8] = byte_en[i] ? wdata_sh[8*i +: 8] : merge_q[8*i +: 8];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            merge_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                we_q    <= req_we;
                f3_q    <= req_func3;
                addr_q  <= req_addr[AW+1:0];
                wdata_q <= req_wdata;
            end
            case (state)
                S_LOAD:   rdata_q <= load_ext;
                S_RMW_RD: merge_q <= mem_rdata;
                S_ERR:    err_q   <= 1'b1;
                S_RESP: begin
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign mem_func3  = 3'b010;

    always_comb begin
        mem_addr  = '0;
        mem_wr    = 1'b0;
        mem_wdata = '0;
        case (state)
            S_LOAD, S_RMW_RD: mem_addr = addr_q[AW+1:2];
            S_WRITE: begin
                mem_addr  = addr_q[AW+1:2];
                mem_wr    = 1'b1;
                mem_wdata = wdata_q;
            end
            S_RMW_WR: begin
                mem_addr  = addr_q[AW+1:2];
                mem_wr    = 1'b1;
                mem_wdata = merged;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lsu_align.sv
// Directed bench for lsu_align with a behavioural word memory behind it.
module tb_lsu_align;

    localparam int AW = 11;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_func3;
    logic [31:0]   req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic          resp_err;
    logic [DW-1:0] resp_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_wr;
    logic [DW-1:0] mem_wdata;
    logic [2:0]    mem_func3;
    logic [DW-1:0] mem_rdata;

    logic [31:0] mem [0:(1<<AW)-1];

    int passed = 0;
    int total  = 0;

    lsu_align #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_func3(mem_func3), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_wr) mem[mem_addr] <= mem_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Issue one request from IDLE and watch 8 cycles for its writes and response.
    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int lat, input logic exp_err, input logic [31:0] exp_rdata,
                          input int exp_nwr, input logic [31:0] exp_wa, input logic [31:0] exp_wd);
        int rc = 0;
        int nwr = 0;
        logic rerr = 1'b0;
        logic [31:0] rdat = '0, wa = '0, wd = '0;
        @(negedge clk);
        chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_func3 = f3; req_addr = addr; req_wdata = wdata;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req_valid = 1'b0;
                chk({tag, "_busy"}, {31'd0, req_ready}, 32'd0);
            end
            if (mem_wr) begin
                nwr++; wa = {21'd0, mem_addr}; wd = mem_wdata;
            end
            if (resp_valid && rc == 0) begin
                rc = c; rerr = resp_err; rdat = resp_rdata;
            end
        end
        chk({tag, "_lat"}, rc, lat);
        chk({tag, "_err"}, {31'd0, rerr}, {31'd0, exp_err});
        chk({tag, "_rdata"}, rdat, exp_rdata);
        chk({tag, "_nwr"}, nwr, exp_nwr);
        if (exp_nwr != 0) begin
            chk({tag, "_waddr"}, wa, exp_wa);
            chk({tag, "_wdata"}, wd, exp_wd);
        end
    endtask

    initial begin
        int nwr, nresp, cyc, idx;
        int acc [0:4];
        logic pend;
        logic        s_we [0:4];
        logic [2:0]  s_f3 [0:4];
        logic [31:0] s_ad [0:4];

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_func3 = 3'd0; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rvalid", {31'd0, resp_valid}, 32'd0);
        chk("rst_memwr", {31'd0, mem_wr}, 32'd0);
        chk("rst_memaddr", {21'd0, mem_addr}, 32'd0);
        chk("rst_memwdata", mem_wdata, 32'd0);
        chk("rst_memf3", {29'd0, mem_func3}, 32'd2);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", {31'd0, resp_err}, 32'd0);
        rst_n = 1'b1;

        // Preload word 5 through the unit itself.
        do_req("sw5", 1'b1, 3'd2, 32'h14, 32'h8877_66F0, 2, 1'b0, 32'd0, 1, 32'd5, 32'h8877_66F0);
        do_req("lb",  1'b0, 3'd0, 32'h14, 32'h0, 2, 1'b0, 32'hFFFF_FFF0, 0, 0, 0);
        do_req("lbu", 1'b0, 3'd4, 32'h15, 32'h0, 2, 1'b0, 32'h0000_0066, 0, 0, 0);
        do_req("lh",  1'b0, 3'd1, 32'h16, 32'h0, 2, 1'b0, 32'hFFFF_8877, 0, 0, 0);
        do_req("sw8", 1'b1, 3'd2, 32'h20, 32'hDEAD_BEEF, 2, 1'b0, 32'd0, 1, 32'd8, 32'hDEAD_BEEF);
        do_req("lw8", 1'b0, 3'd2, 32'h20, 32'h0, 2, 1'b0, 32'hDEAD_BEEF, 0, 0, 0);
        do_req("sb",  1'b1, 3'd0, 32'h22, 32'hAAAA_AA55, 3, 1'b0, 32'd0, 1, 32'd8, 32'hDE55_BEEF);
        do_req("sh",  1'b1, 3'd1, 32'h20, 32'hBBBB_1234, 3, 1'b0, 32'd0, 1, 32'd8, 32'hDE55_1234);
        do_req("lhu", 1'b0, 3'd5, 32'h22, 32'h0, 2, 1'b0, 32'h0000_DE55, 0, 0, 0);
        do_req("hi_addr", 1'b0, 3'd2, 32'hF000_0020, 32'h0, 2, 1'b0, 32'hDE55_1234, 0, 0, 0);
        do_req("e_lw",  1'b0, 3'd2, 32'h21, 32'h0, 2, 1'b1, 32'd0, 0, 0, 0);
        do_req("e_sh",  1'b1, 3'd1, 32'h23, 32'h0, 2, 1'b1, 32'd0, 0, 0, 0);
        do_req("e_ld3", 1'b0, 3'd3, 32'h20, 32'h0, 2, 1'b1, 32'd0, 0, 0, 0);
        do_req("e_st4", 1'b1, 3'd4, 32'h20, 32'h0, 2, 1'b1, 32'd0, 0, 0, 0);
        chk("err_mem_intact", mem[8], 32'hDE55_1234);

        // Reset during RMW_RD of an SB aborts it cleanly.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_func3 = 3'd0; req_addr = 32'h23; req_wdata = 32'h99;
        @(negedge clk);
        req_valid = 1'b0;
        nwr = mem_wr ? 1 : 0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("ar_ready", {31'd0, req_ready}, 32'd1);
        chk("ar_memaddr", {21'd0, mem_addr}, 32'd0);
        chk("ar_memwdata", mem_wdata, 32'd0);
        chk("ar_rdata", resp_rdata, 32'd0);
        rst_n = 1'b1;
        nresp = 0;
        for (int c = 0; c < 6; c++) begin
            if (mem_wr) nwr++;
            if (resp_valid) nresp++;
            @(negedge clk);
        end
        chk("ar_nwr", nwr, 0);
        chk("ar_nresp", nresp, 0);
        chk("ar_mem", mem[8], 32'hDE55_1234);

        // Continuously held req_valid: LW, SW, LW, SB, LW.
        s_we = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        s_f3 = '{3'd2, 3'd2, 3'd2, 3'd0, 3'd2};
        s_ad = '{32'h20, 32'h24, 32'h24, 32'h28, 32'h28};
        idx = 0; pend = 1'b0; nresp = 0; nwr = 0;
        acc = '{0, 0, 0, 0, 0};
        req_valid = 1'b1; req_we = s_we[0]; req_func3 = s_f3[0];
        req_addr = s_ad[0]; req_wdata = 32'h0000_0077;
        for (cyc = 0; cyc < 40; cyc++) begin
            if (pend) begin
                pend = 1'b0;
                idx++;
                if (idx < 5) begin
                    req_we = s_we[idx]; req_func3 = s_f3[idx]; req_addr = s_ad[idx];
                end else begin
                    req_valid = 1'b0;
                end
            end
            if (resp_valid) nresp++;
            if (mem_wr) nwr++;
            if (req_valid && req_ready) begin
                acc[idx] = cyc;
                pend = 1'b1;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("bb_accepts", idx, 5);
        chk("bb_gap0", acc[1] - acc[0], 3);
        chk("bb_gap1", acc[2] - acc[1], 3);
        chk("bb_gap2", acc[3] - acc[2], 3);
        chk("bb_gap3", acc[4] - acc[3], 4);
        chk("bb_nresp", nresp, 5);
        chk("bb_nwr", nwr, 2);
        chk("bb_mem9", mem[9], 32'h0000_0077);
        chk("bb_mem10", mem[10] & 32'hFF, 32'h77);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
